// File: rtl/rs232_rx.sv
// Oversampling 8N1 receiver: synchronises rx, qualifies the start bit, majority-samples
// each bit at ticks 7/8/9 and holds the byte behind a ready/ack handshake with error flags.
module rs232_rx #(
    parameter int OVS_DIV = 78
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    input  logic       rx_ack,
    output logic       ferr,
    output logic       brk,
    output logic       ovr,
    output logic       busy
);

    localparam int PW = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(OVS_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Handshake: rx_ready is a level that stays high until a one-cycle rx_ack;
    // rx_ack while rx_ready is low is ignored.
    state_t        state;
    logic          sync1;
    logic          sync2;
    logic          prev;
    logic [PW-1:0] presc;
    logic [3:0]    tick_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          s7;
    logic          s8;

    logic       tick;
    logic       fall;
    logic       maj;
    logic [3:0] tick_nxt;

    assign tick     = (presc == PRESC_MAX);
    assign fall     = (state == IDLE) && !sync2 && prev;
    assign maj      = (s7 & s8) | (s7 & sync2) | (s8 & sync2);
    assign tick_nxt = tick_cnt + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            prev     <= 1'b0;
            presc    <= '0;
            tick_cnt <= 4'd0;
            bit_cnt  <= 3'd0;
            shreg    <= 8'h00;
            s7       <= 1'b0;
            s8       <= 1'b0;
            rx_data  <= 8'h00;
            rx_ready <= 1'b0;
            ferr     <= 1'b0;
            brk      <= 1'b0;
            ovr      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            prev  <= sync2;
            presc <= tick ? '0 : presc + PW'(1);

            // A completion later in this block overrides these clears.
            if (rx_ack && rx_ready) begin
                rx_ready <= 1'b0;
                ferr     <= 1'b0;
                brk      <= 1'b0;
                ovr      <= 1'b0;
            end

            if (state == IDLE) begin
                if (fall) begin
                    state    <= START;
                    presc    <= '0;
                    tick_cnt <= 4'd0;
                    busy     <= 1'b1;
                end
            end else if (tick) begin
                tick_cnt <= tick_nxt;
                if (tick_nxt == 4'd7) s7 <= sync2;
                if (tick_nxt == 4'd8) s8 <= sync2;

                case (state)
                    START: begin
                        if (tick_nxt == 4'd9 && maj) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (tick_nxt == 4'd15) begin
                            // The detection cycle stands in for the first tick of the
                            // start bit, so the stop decision lands 152 ticks after it.
                            state    <= DATA;
                            bit_cnt  <= 3'd0;
                            tick_cnt <= 4'd0;
                        end
                    end
                    DATA: begin
                        if (tick_nxt == 4'd9) shreg <= {maj, shreg[7:1]};
                        if (tick_nxt == 4'd15) begin
                            if (bit_cnt == 3'd7) state <= STOP;
                            else bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    STOP: begin
                        if (tick_nxt == 4'd9) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (!rx_ready || rx_ack) begin
                                rx_data  <= shreg;
                                rx_ready <= 1'b1;
                                ferr     <= !maj;
                                brk      <= !maj && (shreg == 8'h00);
                            end else begin
                                ovr <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/rs232_rx.md
# rs232_rx

Oversampling RS-232 byte receiver: the stage between the `RS232_Rx` pin and the command parser that loads the pulse parameters (period, widths, delays, nutation, CPMG, blocking). It synchronises the asynchronous line, qualifies the start bit, majority-samples 8N1 frames and holds each received byte behind a ready/ack handshake. It also reports framing, break and overrun conditions. It runs on the 12 MHz base clock, not the PLL clock.

## Interface
- `OVS_DIV`, 78, system clocks per oversample tick; 16 ticks per bit. 78 gives 9600 baud from 12 MHz, a +0.16 % rate error.
- `clk`  in  1  12 MHz base clock; sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial line, idle high.
- `rx_data`  out  8  last accepted byte, LSB received first.
- `rx_ready`  out  1  level; a byte is waiting in `rx_data`.
- `rx_ack`  in  1  one-cycle pulse; consumer has taken `rx_data`.
- `ferr`  out  1  framing error on the byte currently held.
- `brk`  out  1  break on the byte currently held: data 0x00 and stop bit sampled low.
- `ovr`  out  1  sticky; a frame completed while `rx_ready` was high.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **Input path.** `rx` passes through a 2-FF synchroniser. A third flop (`prev`) feeds a falling-edge detector. All three flops reset to 0, so a start requires a high-to-low transition seen after reset. A line held low through reset is ignored until it returns high.
- **Prescaler.**
  - Counts 0..OVS_DIV-1 and emits `tick` on the terminal count.
  - Forced to 0 on start detection, so tick phase aligns to the edge.
  - Tick counter is 4 bits, 0..15 per bit; bit counter is 3 bits.
- **Sampling.** Each bit value is the 2-of-3 majority of the synced samples at ticks 7, 8 and 9.
- **FSM states:**
  - IDLE: falling edge → START, with prescaler and tick counter cleared.
  - START: at tick 9, a majority of 1 means a false start → IDLE, with no flags touched. A majority of 0 continues; at tick 15 → DATA with bit counter = 0.
  - DATA: at tick 9, shift the majority value into a shift register (LSB first). At tick 15, go to STOP after bit 7, otherwise increment the bit counter.
  - STOP: at tick 9, evaluate the stop bit, complete the frame and go to IDLE immediately. The remaining half-bit is not waited out, so an early next start is accepted.
- **Frame completion, `rx_ready` = 0:** load `rx_data`, set `rx_ready` = 1, `ferr` = (stop == 0) and `brk` = (ferr && data == 0).
  - A frame with a framing error is still delivered.
- **Frame completion, `rx_ready` = 1 and no `rx_ack` in the same cycle:** the new byte is discarded. `rx_data`, `ferr` and `brk` are unchanged, and `ovr` is set.
- **`rx_ack` and completion in the same cycle:** the new byte is loaded, `rx_ready` stays 1 and `ovr` is not set.
- **`rx_ack` with no completion:** `rx_ready`, `ferr`, `brk` and `ovr` all clear. `rx_ack` while `rx_ready` = 0 has no effect.
- **After a break:** the FSM returns to IDLE. The line stays low, so no further frame starts until `rx` goes high and falls again.

## Timing
- **Reset values:** `rx_data` = 0x00 and `rx_ready`, `ferr`, `brk`, `ovr`, `busy` = 0. The FSM goes to IDLE, all counters clear, and synchroniser/prev flops = 0.
- **Reset mid-frame:** abandons the frame and produces no completion. The next frame needs a fresh high-to-low transition.
- **Pin to edge detect:** a pin transition reaches the synced output in 2 cycles. The edge is detected on cycle T0, when synced = 0 and `prev` = 1 in IDLE.
- **`busy`:** rises at T0+1.
- **`rx_ready`:** rises at T0 + 152·OVS_DIV + 1 (stop-bit tick 9 is tick number 152 after T0), with a bench tolerance of ±2 cycles. `busy` falls on the same cycle.
- **Outputs:** all registered; no combinational path from `rx` or `rx_ack` to any output.
- **Baud tolerance:** frames must decode correctly for sender rates within ±3 % of nominal.

## Test plan
- **Nominal byte:** send 0xA5 at 9600 baud with a clean stop bit → `rx_data` = 0xA5, `rx_ready` = 1 at T0+11857 ±2, `ferr` = `brk` = `ovr` = 0. Pulse `rx_ack` → `rx_ready` = 0 the next cycle.
- **Glitch rejection:** pulse the line low for 400 cycles (< 7 ticks) → `busy` rises then falls, with no `rx_ready` and no flags. Then send 0x3C → received as 0x3C.
- **Framing error and break:**
  - Send 0x3C with a low stop bit → `rx_data` = 0x3C, `ferr` = 1, `brk` = 0.
  - Hold the line low for 20 bit times → `rx_data` = 0x00, `ferr` = `brk` = 1, and exactly one `rx_ready` until the line returns high.
- **Overrun and coincident ack:**
  - Send 0x11 then 0x22 back-to-back with no ack → `rx_data` = 0x11, `ovr` = 1. Ack → `ovr` = 0.
  - Repeat with `rx_ack` on the exact completion cycle of 0x22 → `rx_data` = 0x22, `rx_ready` held, `ovr` = 0.
- **Reset mid-frame:** assert `reset` for 1 cycle during data bit 4 of 0x5A → outputs 0, no delivery. Send 0x5A again → received correctly.
- **Rate margin:** send 0x96 at 9600·1.03 and 9600·0.97 baud → `rx_data` = 0x96 with `ferr` = 0 in both cases.
